// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg -- shared definitions for the note sequencer.
//   state_t        : FSM state encoding (also exported on the debug port)
//   LEN_CODE_*     : 3-bit note length codes as stored in the song ROM
//   BEATS_*        : beat counts those codes decode to
// Optional feature macro used by the sequencer: NOTE_SEQ_LOOP_EN.
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LEN_CODE_HALF    = 3'd0;
  localparam logic [2:0] LEN_CODE_QUARTER = 3'd1;
  localparam logic [2:0] LEN_CODE_DOT     = 3'd2;
  localparam logic [2:0] LEN_CODE_WHOLE   = 3'd3;
  localparam logic [2:0] LEN_CODE_LONG    = 3'd4;

  localparam logic [3:0] BEATS_HALF    = 4'd2;
  localparam logic [3:0] BEATS_QUARTER = 4'd1;
  localparam logic [3:0] BEATS_DOT     = 4'd3;
  localparam logic [3:0] BEATS_WHOLE   = 4'd4;
  localparam logic [3:0] BEATS_LONG    = 4'd12;
  localparam logic [3:0] BEATS_END     = 4'd0;

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if -- song ROM read bus.
//   rom_addr : read address, driven by the sequencer (master)
//   rom_data : {length[2:0], pitch}, driven by the ROM (slave)
// Bus timing: there is no valid/ready pair. The ROM is a synchronous read
// port with a fixed latency of one cycle: rom_data is valid in the cycle
// after rom_addr was presented, and the ROM can never stall the master.
interface note_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int PITCH_W = 6
);
  logic [ADDR_W-1:0]    rom_addr;
  logic [PITCH_W+2:0]   rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/note_sequencer_length_decoder.sv
// length_decoder -- combinational map from a 3-bit note length code to a
// beat count. Codes 5..7 decode to 0, which the sequencer treats as the
// end-of-song marker.
//   code  : length code from the ROM word
//   beats : beats the note lasts (0 = end marker)
module length_decoder
  import note_sequencer_pkg::*;
(
  input  logic [2:0] code,
  output logic [3:0] beats
);
  always_comb begin
    beats = BEATS_END;
    unique case (code)
      LEN_CODE_HALF:    beats = BEATS_HALF;
      LEN_CODE_QUARTER: beats = BEATS_QUARTER;
      LEN_CODE_DOT:     beats = BEATS_DOT;
      LEN_CODE_WHOLE:   beats = BEATS_WHOLE;
      LEN_CODE_LONG:    beats = BEATS_LONG;
      default:          beats = BEATS_END;
    endcase
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer -- steps through a song ROM, sounding one note per entry
// for a number of beat_tick pulses given by the entry's length code.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start       : pulse, (re)starts playback from address 0
//   pause       : level, freezes a sounding note
//   beat_tick   : pulse per beat unit
//   rom         : song ROM bus (master side)
//   pitch       : pitch of the sounding note
//   note_valid  : high while a note sounds
//   busy        : high in FETCH/LOAD/PLAY
//   done        : one-cycle pulse on entry to DONE
//   dbg_state   : current FSM state
//   dbg_count   : remaining beats of the current note
// Macro NOTE_SEQ_LOOP_EN: song end returns to address 0 instead of DONE.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int PITCH_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               beat_tick,
  note_sequencer_if.master   rom,
  output logic [PITCH_W-1:0] pitch,
  output logic               note_valid,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state,
  output logic [3:0]         dbg_count
);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   addr, next_addr;
  logic [PITCH_W-1:0]  next_pitch;
  logic [3:0]          count, next_count;
  logic                next_valid, next_done, next_busy;
  logic                song_end;
  logic [3:0]          beats;

  length_decoder length_decoder (
    .code  (rom.rom_data[PITCH_W+2:PITCH_W]),
    .beats (beats)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      pitch      <= '0;
      count      <= '0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      addr       <= next_addr;
      pitch      <= next_pitch;
      count      <= next_count;
      note_valid <= next_valid;
      busy       <= next_busy;
      done       <= next_done;
    end
  end

  always_comb begin
    next_state = state;
    next_addr  = addr;
    next_pitch = pitch;
    next_count = count;
    next_valid = note_valid;
    next_done  = 1'b0;
    song_end   = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = FETCH;
          next_addr  = '0;
        end
      end
      FETCH: begin
        // FETCH and LOAD always advance, even under pause, so the ROM word
        // is captured; the pause then takes hold once PLAY is entered.
        if (start) begin
          next_state = FETCH;
          next_addr  = '0;
          next_valid = 1'b0;
        end else begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (start) begin
          next_state = FETCH;
          next_addr  = '0;
          next_valid = 1'b0;
        end else if (beats == BEATS_END) begin
          song_end = 1'b1;
        end else begin
          next_pitch = rom.rom_data[PITCH_W-1:0];
          next_count = beats;
          next_valid = 1'b1;
          next_state = PLAY;
        end
      end
      PLAY: begin
        // start beats a coincident beat_tick
        if (start) begin
          next_state = FETCH;
          next_addr  = '0;
          next_valid = 1'b0;
        end else if (!pause && beat_tick) begin
          if (count == 4'd1) begin
            next_valid = 1'b0;
            next_count = '0;
            if (addr == ADDR_LAST) begin
              song_end = 1'b1;
            end else begin
              next_addr  = addr + 1'b1;
              next_state = FETCH;
            end
          end else begin
            next_count = count - 4'd1;
          end
        end
      end
      default: next_state = IDLE;
    endcase

    if (song_end) begin
`ifdef NOTE_SEQ_LOOP_EN
      next_state = FETCH;
      next_addr  = '0;
`else
      next_state = DONE;
      next_done  = 1'b1;
`endif
    end

    next_busy = (next_state == FETCH) || (next_state == LOAD) ||
                (next_state == PLAY);
  end

  assign rom.rom_addr = addr;
  assign dbg_state    = state;
  assign dbg_count    = count;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer -- directed bench for note_sequencer with a
// behavioural one-cycle-latency song ROM.
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       beat_tick;
  logic [5:0] pitch;
  logic       note_valid;
  logic       busy;
  logic       done;
  state_t     dbg_state;
  logic [3:0] dbg_count;

  int tests = 0;
  int fails = 0;
  int done_count = 0;

  logic [8:0] rom_mem [64];

  note_sequencer_if #(.ADDR_W(6), .PITCH_W(6)) bus ();

  note_sequencer #(.ADDR_W(6), .PITCH_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .beat_tick  (beat_tick),
    .rom        (bus.master),
    .pitch      (pitch),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // clock / ROM / done monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  always @(posedge clk) if (done === 1'b1) done_count++;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat();
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
  endtask

  function automatic logic [8:0] ent(input int len, input int p);
    logic [2:0] l;
    logic [5:0] q;
    l = len[2:0];
    q = p[5:0];
    return {l, q};
  endfunction

  task automatic do_reset();
    start     = 1'b0;
    pause     = 1'b0;
    beat_tick = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = ent(7, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    done_count = 0;
  endtask

  // tests
  task automatic test_reset();
    start     = 1'b0;
    pause     = 1'b0;
    beat_tick = 1'b0;
    rst = 1'b1;
    step();
    tests++;
    if (dbg_state !== IDLE || bus.rom_addr !== 6'd0 || pitch !== 6'd0 ||
        dbg_count !== 4'd0 || note_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: state=%0d addr=%0d pitch=%0d cnt=%0d nv=%b busy=%b done=%b expected all zero/IDLE",
               dbg_state, bus.rom_addr, pitch, dbg_count, note_valid, busy, done);
    end
    rst = 1'b0;
  endtask

`ifndef NOTE_SEQ_LOOP_EN
  task automatic test_song();
    do_reset();
    rom_mem[0] = ent(1, 5);
    rom_mem[1] = ent(0, 9);
    rom_mem[2] = ent(7, 0);
    pulse_start();
    tests++;
    if (dbg_state !== FETCH || busy !== 1'b1 || bus.rom_addr !== 6'd0) begin
      fails++;
      $display("FAIL song_fetch: state=%0d busy=%b addr=%0d expected FETCH 1 0", dbg_state, busy, bus.rom_addr);
    end
    step();
    step();
    tests++;
    if (pitch !== 6'd5 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL song_note1: pitch=%0d nv=%b expected 5 1", pitch, note_valid);
    end
    repeat (3) step();
    beat();
    tests++;
    if (note_valid !== 1'b0 || bus.rom_addr !== 6'd1) begin
      fails++;
      $display("FAIL song_gap1: nv=%b addr=%0d expected 0 1", note_valid, bus.rom_addr);
    end
    repeat (3) step();
    tests++;
    if (pitch !== 6'd9 || note_valid !== 1'b1 || dbg_count !== 4'd2) begin
      fails++;
      $display("FAIL song_note2: pitch=%0d nv=%b cnt=%0d expected 9 1 2", pitch, note_valid, dbg_count);
    end
    beat();
    tests++;
    if (note_valid !== 1'b1 || dbg_count !== 4'd1) begin
      fails++;
      $display("FAIL song_note2_tick1: nv=%b cnt=%0d expected 1 1", note_valid, dbg_count);
    end
    repeat (3) step();
    beat();
    step();
    step();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || note_valid !== 1'b0 || pitch !== 6'd9 || dbg_state !== DONE) begin
      fails++;
      $display("FAIL song_done: done=%b busy=%b nv=%b pitch=%0d state=%0d expected 1 0 0 9 DONE",
               done, busy, note_valid, pitch, dbg_state);
    end
    step();
    tests++;
    if (done !== 1'b0 || done_count != 1) begin
      fails++;
      $display("FAIL song_done_pulse: done=%b pulses=%0d expected 0 1", done, done_count);
    end
  endtask

  task automatic test_long_note();
    do_reset();
    rom_mem[0] = ent(4, 3);
    pulse_start();
    step();
    step();
    tests++;
    if (pitch !== 6'd3 || note_valid !== 1'b1 || dbg_count !== 4'd12) begin
      fails++;
      $display("FAIL long_start: pitch=%0d nv=%b cnt=%0d expected 3 1 12", pitch, note_valid, dbg_count);
    end
    for (int i = 1; i < 12; i++) begin
      beat();
      tests++;
      if (note_valid !== 1'b1 || dbg_count !== 4'(12 - i)) begin
        fails++;
        $display("FAIL long_tick%0d: nv=%b cnt=%0d expected 1 %0d", i, note_valid, dbg_count, 12 - i);
      end
    end
    beat();
    tests++;
    if (note_valid !== 1'b0 || bus.rom_addr !== 6'd1) begin
      fails++;
      $display("FAIL long_end: nv=%b addr=%0d expected 0 1", note_valid, bus.rom_addr);
    end
  endtask

  task automatic test_restart();
    do_reset();
    rom_mem[0] = ent(0, 1);
    rom_mem[1] = ent(0, 2);
    rom_mem[2] = ent(0, 3);
    pulse_start();
    step();
    step();
    beat();
    beat();
    step();
    step();
    beat();
    beat();
    step();
    step();
    tests++;
    if (pitch !== 6'd3 || bus.rom_addr !== 6'd2 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL restart_note3: pitch=%0d addr=%0d nv=%b expected 3 2 1", pitch, bus.rom_addr, note_valid);
    end
    beat();
    // start and the note-ending tick together: start must win
    start = 1'b1;
    beat_tick = 1'b1;
    step();
    start = 1'b0;
    beat_tick = 1'b0;
    tests++;
    if (bus.rom_addr !== 6'd0 || note_valid !== 1'b0 || dbg_state !== FETCH) begin
      fails++;
      $display("FAIL restart_go: addr=%0d nv=%b state=%0d expected 0 0 FETCH", bus.rom_addr, note_valid, dbg_state);
    end
    step();
    step();
    tests++;
    if (pitch !== 6'd1 || note_valid !== 1'b1 || dbg_count !== 4'd2) begin
      fails++;
      $display("FAIL restart_replay: pitch=%0d nv=%b cnt=%0d expected 1 1 2", pitch, note_valid, dbg_count);
    end
  endtask

  task automatic test_async_rst();
    do_reset();
    rom_mem[0] = ent(2, 5);
    pulse_start();
    step();
    step();
    beat();
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (pitch !== 6'd0 || note_valid !== 1'b0 || bus.rom_addr !== 6'd0 || busy !== 1'b0 ||
        done !== 1'b0 || dbg_state !== IDLE || dbg_count !== 4'd0) begin
      fails++;
      $display("FAIL async_rst: pitch=%0d nv=%b addr=%0d busy=%b done=%b state=%0d cnt=%0d expected zeros IDLE",
               pitch, note_valid, bus.rom_addr, busy, done, dbg_state, dbg_count);
    end
    step();
    rst = 1'b0;
    repeat (5) step();
    tests++;
    if (dbg_state !== IDLE || done_count != 0) begin
      fails++;
      $display("FAIL async_rst_after: state=%0d pulses=%0d expected IDLE 0", dbg_state, done_count);
    end
  endtask

  task automatic test_last_addr();
    do_reset();
    for (int i = 0; i < 64; i++) rom_mem[i] = ent(1, i);
    pulse_start();
    step();
    step();
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (pitch !== 6'(i) || note_valid !== 1'b1) begin
        fails++;
        $display("FAIL last_note%0d: pitch=%0d nv=%b expected %0d 1", i, pitch, note_valid, i);
      end
      beat();
      if (i < 63) begin
        step();
        step();
      end
    end
    tests++;
    if (dbg_state !== DONE || done !== 1'b1 || bus.rom_addr !== 6'd63 || note_valid !== 1'b0) begin
      fails++;
      $display("FAIL last_done: state=%0d done=%b addr=%0d nv=%b expected DONE 1 63 0",
               dbg_state, done, bus.rom_addr, note_valid);
    end
  endtask
`endif

  task automatic test_pause();
    do_reset();
    rom_mem[0] = ent(3, 7);
    pulse_start();
    step();
    step();
    beat();
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      beat_tick = (i % 4 == 0);
      step();
    end
    beat_tick = 1'b0;
    tests++;
    if (dbg_count !== 4'd3 || pitch !== 6'd7 || note_valid !== 1'b1 ||
        dbg_state !== PLAY || bus.rom_addr !== 6'd0) begin
      fails++;
      $display("FAIL pause_hold: cnt=%0d pitch=%0d nv=%b state=%0d addr=%0d expected 3 7 1 PLAY 0",
               dbg_count, pitch, note_valid, dbg_state, bus.rom_addr);
    end
    pause = 1'b0;
    beat();
    beat();
    tests++;
    if (dbg_count !== 4'd1 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL pause_resume: cnt=%0d nv=%b expected 1 1", dbg_count, note_valid);
    end
    beat();
    tests++;
    if (note_valid !== 1'b0 || bus.rom_addr !== 6'd1) begin
      fails++;
      $display("FAIL pause_end: nv=%b addr=%0d expected 0 1", note_valid, bus.rom_addr);
    end
  endtask

`ifdef NOTE_SEQ_LOOP_EN
  task automatic test_loop();
    do_reset();
    rom_mem[0] = ent(0, 1);
    rom_mem[1] = ent(1, 2);
    pulse_start();
    tests++;
    if (bus.rom_addr !== 6'd0 || dbg_state !== FETCH) begin
      fails++;
      $display("FAIL loop_a0: addr=%0d state=%0d expected 0 FETCH", bus.rom_addr, dbg_state);
    end
    step();
    step();
    beat();
    beat();
    tests++;
    if (bus.rom_addr !== 6'd1) begin
      fails++;
      $display("FAIL loop_a1: addr=%0d expected 1", bus.rom_addr);
    end
    step();
    step();
    beat();
    tests++;
    if (bus.rom_addr !== 6'd2) begin
      fails++;
      $display("FAIL loop_a2: addr=%0d expected 2", bus.rom_addr);
    end
    step();
    step();
    tests++;
    if (bus.rom_addr !== 6'd0 || dbg_state !== FETCH || busy !== 1'b1) begin
      fails++;
      $display("FAIL loop_wrap: addr=%0d state=%0d busy=%b expected 0 FETCH 1", bus.rom_addr, dbg_state, busy);
    end
    step();
    step();
    tests++;
    if (pitch !== 6'd1 || note_valid !== 1'b1) begin
      fails++;
      $display("FAIL loop_replay: pitch=%0d nv=%b expected 1 1", pitch, note_valid);
    end
    beat();
    beat();
    tests++;
    if (bus.rom_addr !== 6'd1 || done_count != 0) begin
      fails++;
      $display("FAIL loop_a1_again: addr=%0d pulses=%0d expected 1 0", bus.rom_addr, done_count);
    end
  endtask
`endif

  // sequence and report
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pause     = 1'b0;
    beat_tick = 1'b0;
    for (int i = 0; i < 64; i++) rom_mem[i] = ent(7, 0);
    test_reset();
    test_pause();
`ifdef NOTE_SEQ_LOOP_EN
    test_loop();
`else
    test_song();
    test_long_note();
    test_restart();
    test_async_rst();
    test_last_addr();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
